mod_n_counter: RTL

//   Parametrised modulo-N counter, successor to the fixed 3-bit mod-6 counter.

---
 rtl/mod_n_counter.sv | 69 ++++++
 1 files changed

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with synchronous load, a combinational
// terminal flag for same-cycle cascading, and registered wrap / load_err pulses.
module mod_n_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
            $error("mod_n_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    // Range checks use one extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic             at_max;
    logic             at_zero;
    logic             count_illegal;
    logic             load_illegal;
    logic [WIDTH-1:0] count_next;

    assign at_max        = (count == MAX_COUNT);
    assign at_zero       = (count == '0);
    assign count_illegal = ({1'b0, count} >= MOD_EXT);
    assign load_illegal  = ({1'b0, load_value} >= MOD_EXT);
    assign terminal      = enable & (up ? at_max : at_zero);

    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_illegal ? '0 : load_value;
        end else if (enable) begin
            if (count_illegal) begin
                count_next = '0;
            end else if (up) begin
                count_next = at_max ? '0 : count + ONE;
            end else begin
                count_next = at_zero ? MAX_COUNT : count - ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_next;
            wrap     <= terminal & ~load;
            load_err <= load & load_illegal;
        end
    end

endmodule
